// File: rtl/unidade_mult_div_if.sv
// Bus bundle for the multiply/divide unit: start request, operands,
// MTHI/MTLO writes, MFHI/MFLO read-back and status flags.
interface unidade_mult_div_if #(
    parameter int LARGURA = 32
);
    logic               inicio;
    logic [1:0]         operacao;
    logic [LARGURA-1:0] operando_a;
    logic [LARGURA-1:0] operando_b;
    logic               escrita_hi;
    logic               escrita_lo;
    logic [LARGURA-1:0] dado_mt;
    logic               sel_hi;
    logic [LARGURA-1:0] saida_dado;
    logic [LARGURA-1:0] hi;
    logic [LARGURA-1:0] lo;
    logic               ocupado;
    logic               pronto;
    logic               erro_div0;

    modport master (
        output inicio, operacao, operando_a, operando_b,
               escrita_hi, escrita_lo, dado_mt, sel_hi,
        input  saida_dado, hi, lo, ocupado, pronto, erro_div0
    );

    modport slave (
        input  inicio, operacao, operando_a, operando_b,
               escrita_hi, escrita_lo, dado_mt, sel_hi,
        output saida_dado, hi, lo, ocupado, pronto, erro_div0
    );
endinterface

// File: rtl/unidade_mult_div.sv
// Iterative HI/LO multiply/divide unit. Works on operand magnitudes for
// LARGURA cycles (shift-add multiply or restoring divide), applies sign
// correction for one cycle, then pulses pronto. HI/LO only change on MT
// writes while idle, on a finished operation, or on divide-by-zero.
module unidade_mult_div #(
    parameter int LARGURA = 32
) (
    input logic                 clock,
    input logic                 reset,
    unidade_mult_div_if.slave   bus
);
    localparam int CW = (LARGURA > 1) ? $clog2(LARGURA) : 1;
    localparam logic [CW-1:0] ULTIMO = CW'(LARGURA - 1);

    typedef enum logic [1:0] {
        OCIOSO,
        CALCULA,
        AJUSTE,
        CONCLUIDO
    } estado_t;

    estado_t estado, proximo;

    logic [LARGURA-1:0]   hi_r, lo_r;
    logic                 erro_r;
    logic [LARGURA-1:0]   alta, baixa, fator;
    logic [CW-1:0]        contador;
    logic                 divisao, sinal_a, sinal_b;
    logic                 ocupado_i, pronto_i;

    // Operand conditioning for the request currently on the bus
    logic                 com_sinal, ent_sinal_a, ent_sinal_b, div_zero;
    logic [LARGURA-1:0]   mag_a, mag_b;

    // Per-iteration datapath and final sign-corrected results
    logic [LARGURA:0]     soma, desloc, dif;
    logic [LARGURA-1:0]   prox_alta, prox_baixa;
    logic [2*LARGURA-1:0] produto, produto_final;
    logic [LARGURA-1:0]   quociente, resto, hi_final, lo_final;

    // Magnitudes and sign flags of the incoming operands
    always_comb begin
        com_sinal   = ~bus.operacao[0];
        ent_sinal_a = com_sinal & bus.operando_a[LARGURA-1];
        ent_sinal_b = com_sinal & bus.operando_b[LARGURA-1];
        mag_a       = ent_sinal_a ? -bus.operando_a : bus.operando_a;
        mag_b       = ent_sinal_b ? -bus.operando_b : bus.operando_b;
        div_zero    = bus.operacao[1] && (bus.operando_b == '0);
    end

    // One shift-add or restoring-divide step on {alta, baixa}
    always_comb begin
        soma   = {1'b0, alta} + {1'b0, (baixa[0] ? fator : '0)};
        desloc = {alta, baixa[LARGURA-1]};
        dif    = desloc - {1'b0, fator};
        if (divisao) begin
            prox_alta  = dif[LARGURA] ? desloc[LARGURA-1:0] : dif[LARGURA-1:0];
            prox_baixa = {baixa[LARGURA-2:0], ~dif[LARGURA]};
        end else begin
            prox_alta  = soma[LARGURA:1];
            prox_baixa = {soma[0], baixa[LARGURA-1:1]};
        end
    end

    // Sign correction: product/quotient negate on differing signs,
    // remainder follows the dividend sign
    always_comb begin
        produto       = {alta, baixa};
        produto_final = (sinal_a ^ sinal_b) ? -produto : produto;
        quociente     = (sinal_a ^ sinal_b) ? -baixa : baixa;
        resto         = sinal_a ? -alta : alta;
        hi_final      = divisao ? resto : produto_final[2*LARGURA-1:LARGURA];
        lo_final      = divisao ? quociente : produto_final[LARGURA-1:0];
    end

    // State register
    always_ff @(posedge clock) begin
        if (reset) estado <= OCIOSO;
        else       estado <= proximo;
    end

    // Next-state and status outputs
    always_comb begin
        proximo   = estado;
        ocupado_i = 1'b0;
        pronto_i  = 1'b0;
        case (estado)
            OCIOSO: begin
                if (bus.inicio) proximo = div_zero ? CONCLUIDO : CALCULA;
            end
            CALCULA: begin
                ocupado_i = 1'b1;
                if (contador == ULTIMO) proximo = AJUSTE;
            end
            AJUSTE: begin
                ocupado_i = 1'b1;
                proximo   = CONCLUIDO;
            end
            CONCLUIDO: begin
                pronto_i = 1'b1;
                proximo  = OCIOSO;
            end
            default: proximo = OCIOSO;
        endcase
    end

    // HI/LO, error flag and iteration datapath
    always_ff @(posedge clock) begin
        if (reset) begin
            hi_r     <= '0;
            lo_r     <= '0;
            erro_r   <= 1'b0;
            alta     <= '0;
            baixa    <= '0;
            fator    <= '0;
            contador <= '0;
            divisao  <= 1'b0;
            sinal_a  <= 1'b0;
            sinal_b  <= 1'b0;
        end else begin
            case (estado)
                OCIOSO: begin
                    if (bus.escrita_hi) hi_r <= bus.dado_mt;
                    if (bus.escrita_lo) lo_r <= bus.dado_mt;
                    if (bus.inicio) begin
                        // A divide-by-zero result lands on the same edge as
                        // any MT write, so it takes precedence here.
                        if (div_zero) begin
                            erro_r <= 1'b1;
                            hi_r   <= bus.operando_a;
                            lo_r   <= '1;
                        end else begin
                            erro_r   <= 1'b0;
                            divisao  <= bus.operacao[1];
                            sinal_a  <= ent_sinal_a;
                            sinal_b  <= ent_sinal_b;
                            fator    <= mag_b;
                            alta     <= '0;
                            baixa    <= mag_a;
                            contador <= '0;
                        end
                    end
                end
                CALCULA: begin
                    alta     <= prox_alta;
                    baixa    <= prox_baixa;
                    contador <= contador + 1'b1;
                end
                AJUSTE: begin
                    hi_r <= hi_final;
                    lo_r <= lo_final;
                end
                default: ;
            endcase
        end
    end

    assign bus.hi         = hi_r;
    assign bus.lo         = lo_r;
    assign bus.erro_div0  = erro_r;
    assign bus.ocupado    = ocupado_i;
    assign bus.pronto     = pronto_i;
    assign bus.saida_dado = bus.sel_hi ? hi_r : lo_r;
endmodule

// File: tb/tb_unidade_mult_div.sv
// Bench for unidade_mult_div: cycle-level reference model plus directed
// vectors with hand-computed HI/LO values and latencies.
module tb_unidade_mult_div;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad   = 0;
    logic ativo = 1'b0;

    unidade_mult_div_if #(.LARGURA(32)) bus ();
    unidade_mult_div #(.LARGURA(32)) dut (.clock(clock), .reset(reset), .bus(bus.slave));

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    task automatic compara(input string nome, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h at %0t", nome, got, want, $time);
        end
    endtask

    // Reference: arithmetic result of an operation as {hi, lo}
    function automatic logic [63:0] resultado(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        longint unsigned ua, ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (op)
            2'b00: return sa * sb;
            2'b01: return ua * ub;
            2'b10: begin
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            default: return {a % b, a / b};
        endcase
    endfunction

    // Model state: m_t = cycles since an accepted start (0 idle, 1..33 busy, 34 done)
    logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
    logic        m_err = 1'b0;
    int          m_t = 0;

    always @(posedge clock) begin
        logic [63:0] r;
        if (reset) begin
            m_hi = '0; m_lo = '0; m_err = 1'b0; m_t = 0;
        end else if (m_t == 0) begin
            if (bus.escrita_hi) m_hi = bus.dado_mt;
            if (bus.escrita_lo) m_lo = bus.dado_mt;
            if (bus.inicio) begin
                if (bus.operacao[1] && bus.operando_b == 32'd0) begin
                    m_hi = bus.operando_a; m_lo = '1; m_err = 1'b1; m_t = 34;
                end else begin
                    r = resultado(bus.operacao, bus.operando_a, bus.operando_b);
                    p_hi = r[63:32]; p_lo = r[31:0]; m_err = 1'b0; m_t = 1;
                end
            end
        end else if (m_t == 33) begin
            m_hi = p_hi; m_lo = p_lo; m_t = 34;
        end else if (m_t == 34) begin
            m_t = 0;
        end else begin
            m_t++;
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clock) begin
        if (ativo) begin
            compara("ocupado", {31'd0, bus.ocupado}, {31'd0, (m_t >= 1 && m_t <= 33)});
            compara("pronto", {31'd0, bus.pronto}, {31'd0, (m_t == 34)});
            compara("erro_div0", {31'd0, bus.erro_div0}, {31'd0, m_err});
            compara("hi", bus.hi, m_hi);
            compara("lo", bus.lo, m_lo);
            compara("saida_dado", bus.saida_dado, bus.sel_hi ? m_hi : m_lo);
        end
    end

    task automatic passo();
        @(negedge clock);
        #2;
    endtask

    task automatic espera_pronto(input int ja, output int lat);
        int k;
        k = ja;
        lat = -1;
        while (k < 60) begin
            @(negedge clock);
            k++;
            if (bus.pronto) begin
                lat = k;
                break;
            end
        end
        #2;
    endtask

    // Starts an operation (caller at negedge+2); returns at pronto negedge+2
    task automatic executa(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, output int lat);
        bus.operacao = op; bus.operando_a = a; bus.operando_b = b; bus.inicio = 1'b1;
        @(negedge clock);
        if (bus.pronto) begin
            lat = 1;
            #2;
        end else begin
            #2;
            bus.inicio = 1'b0; bus.escrita_hi = 1'b0; bus.escrita_lo = 1'b0;
            espera_pronto(1, lat);
        end
        bus.inicio = 1'b0; bus.escrita_hi = 1'b0; bus.escrita_lo = 1'b0;
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a, b, e_hi, e_lo;
        int          lat;
    } vetor_t;

    vetor_t vetores[12] = '{
        '{2'b00, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA, 34},
        '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 34},
        '{2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 34},
        '{2'b11, 32'h00000007, 32'h00000000, 32'h00000007, 32'hFFFFFFFF, 1},
        '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 34},
        '{2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 34},
        '{2'b10, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 34},
        '{2'b11, 32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF, 34},
        '{2'b01, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780, 34},
        '{2'b10, 32'h00000000, 32'h00000005, 32'h00000000, 32'h00000000, 34},
        '{2'b00, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9, 34},
        '{2'b10, 32'h80000000, 32'h00000000, 32'h80000000, 32'hFFFFFFFF, 1}
    };

    initial begin
        int lat;
        bus.inicio = 1'b0; bus.operacao = 2'b00; bus.operando_a = '0; bus.operando_b = '0;
        bus.escrita_hi = 1'b0; bus.escrita_lo = 1'b0; bus.dado_mt = '0; bus.sel_hi = 1'b0;

        repeat (2) @(negedge clock);
        ativo = 1'b1;
        compara("reset hi", bus.hi, 32'h0);
        compara("reset lo", bus.lo, 32'h0);
        compara("reset ocupado", {31'd0, bus.ocupado}, 32'h0);
        compara("reset erro", {31'd0, bus.erro_div0}, 32'h0);
        #2 reset = 1'b0;

        // MTHI / MTLO while idle, read back through both selections
        bus.escrita_hi = 1'b1; bus.dado_mt = 32'h00000055;
        passo();
        bus.escrita_hi = 1'b0; bus.escrita_lo = 1'b1; bus.dado_mt = 32'h000000AA; bus.sel_hi = 1'b1;
        passo();
        bus.escrita_lo = 1'b0;
        compara("mthi readback", bus.saida_dado, 32'h00000055);
        bus.sel_hi = 1'b0;
        passo();
        compara("mtlo readback", bus.saida_dado, 32'h000000AA);

        // Directed vectors
        foreach (vetores[i]) begin
            executa(vetores[i].op, vetores[i].a, vetores[i].b, lat);
            compara($sformatf("v%0d latencia", i), 32'(lat), 32'(vetores[i].lat));
            compara($sformatf("v%0d hi", i), bus.hi, vetores[i].e_hi);
            compara($sformatf("v%0d lo", i), bus.lo, vetores[i].e_lo);
            compara($sformatf("v%0d erro", i), {31'd0, bus.erro_div0}, {31'd0, (vetores[i].lat == 1)});
            if (i == 1) begin
                // start during the completion cycle must be dropped
                bus.inicio = 1'b1; bus.operacao = 2'b01; bus.operando_a = 32'd9; bus.operando_b = 32'd9;
                passo();
                bus.inicio = 1'b0;
                compara("inicio em concluido", {31'd0, bus.ocupado}, 32'h0);
            end
            passo();
        end

        // Error flag sticks across idle cycles, clears on next good start
        executa(2'b11, 32'd7, 32'd0, lat);
        repeat (3) passo();
        compara("erro pegajoso", {31'd0, bus.erro_div0}, 32'h1);

        // MTLO together with a start: write lands, result later overwrites
        bus.escrita_lo = 1'b1; bus.dado_mt = 32'h00000077;
        executa(2'b11, 32'd100, 32'd7, lat);
        compara("mt+inicio hi", bus.hi, 32'd2);
        compara("mt+inicio lo", bus.lo, 32'd14);
        compara("mt+inicio erro", {31'd0, bus.erro_div0}, 32'h0);
        passo();

        // Start and MTHI during a running op are ignored
        bus.inicio = 1'b1; bus.operacao = 2'b01; bus.operando_a = 32'd1000; bus.operando_b = 32'd3000;
        passo();
        bus.inicio = 1'b0;
        repeat (4) passo();
        bus.inicio = 1'b1; bus.operacao = 2'b00; bus.operando_a = 32'd5; bus.operando_b = 32'd5;
        bus.escrita_hi = 1'b1; bus.dado_mt = 32'h00001234;
        passo();
        bus.inicio = 1'b0; bus.escrita_hi = 1'b0;
        espera_pronto(6, lat);
        compara("ocupado ignora latencia", 32'(lat), 32'd34);
        compara("ocupado ignora hi", bus.hi, 32'h0);
        compara("ocupado ignora lo", bus.lo, 32'h002DC6C0);
        passo();

        // Reset partway through a MULT: no pronto, HI/LO cleared
        bus.inicio = 1'b1; bus.operacao = 2'b00; bus.operando_a = 32'd5; bus.operando_b = 32'd6;
        passo();
        bus.inicio = 1'b0;
        repeat (8) passo();
        reset = 1'b1;
        passo();
        reset = 1'b0;
        repeat (40) passo();
        compara("abort hi", bus.hi, 32'h0);
        compara("abort lo", bus.lo, 32'h0);
        bus.escrita_lo = 1'b1; bus.dado_mt = 32'h0000ABCD; bus.sel_hi = 1'b0;
        passo();
        bus.escrita_lo = 1'b0;
        compara("mtlo apos abort", bus.saida_dado, 32'h0000ABCD);

        // Reset wins over a simultaneous start and MT write
        reset = 1'b1; bus.inicio = 1'b1; bus.operacao = 2'b01;
        bus.operando_a = 32'd3; bus.operando_b = 32'd3;
        bus.escrita_hi = 1'b1; bus.dado_mt = 32'h0000FFFF;
        passo();
        reset = 1'b0; bus.inicio = 1'b0; bus.escrita_hi = 1'b0;
        compara("prioridade hi", bus.hi, 32'h0);
        compara("prioridade lo", bus.lo, 32'h0);
        compara("prioridade ocupado", {31'd0, bus.ocupado}, 32'h0);
        repeat (3) passo();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/unidade_mult_div.md
UNIDADE_MULT_DIV -- requirements
Module: unidade_mult_div

Interface
REQ-001 The block SHALL have parameter LARGURA, default 32, giving the operand and HI/LO width in bits.
REQ-002 The block SHALL have port clock, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit, synchronous and active-high.
REQ-004 The block SHALL have port inicio, input, 1 bit, a start request sampled on the rising edge.
REQ-005 The block SHALL have port operacao, input, 2 bits: 00 MULT signed, 01 MULTU, 10 DIV signed, 11 DIVU.
REQ-006 The block SHALL have port operando_a, input, LARGURA bits, fed from register-file saida_RS (multiplicand/dividend).
REQ-007 The block SHALL have port operando_b, input, LARGURA bits, fed from register-file saida_RT (multiplier/divisor).
REQ-008 The block SHALL have ports escrita_hi and escrita_lo, input, 1 bit each, for MTHI/MTLO.
REQ-009 The block SHALL have port dado_mt, input, LARGURA bits, the value written by MTHI/MTLO.
REQ-010 The block SHALL have port sel_hi, input, 1 bit, selecting saida_dado: 1 = HI, 0 = LO (MFHI/MFLO).
REQ-011 The block SHALL have port saida_dado, output, LARGURA bits, combinational HI or LO per sel_hi, routed to register-file dado_wrt.
REQ-012 The block SHALL have ports hi and lo, output, LARGURA bits each, the registered HI/LO values.
REQ-013 The block SHALL have port ocupado, output, 1 bit, high while an operation is in progress.
REQ-014 The block SHALL have port pronto, output, 1 bit, a one-cycle completion pulse.
REQ-015 The block SHALL have port erro_div0, output, 1 bit, sticky divide-by-zero flag.

Function
REQ-016 The state machine SHALL have states OCIOSO, CALCULA, AJUSTE and CONCLUIDO.
REQ-017 In OCIOSO, inicio=1 SHALL latch operacao, operando_a and operando_b, and move to CALCULA (or to CONCLUIDO on division with operando_b=0).
REQ-018 CALCULA SHALL perform exactly LARGURA iterations, one per cycle (shift-add multiply, restoring divide), on operand magnitudes for signed ops.
REQ-019 AJUSTE SHALL apply sign correction for one cycle: signed product negated when operand signs differ; quotient truncated toward zero; remainder takes dividend sign.
REQ-020 CONCLUIDO SHALL last one cycle, assert pronto, and return to OCIOSO.
REQ-021 With inicio sampled in cycle N, ocupado SHALL be 1 in cycles N+1..N+33, pronto SHALL be 1 in cycle N+34, and hi/lo SHALL hold the result from cycle N+34 onward.
REQ-022 Multiplication SHALL place the 2*LARGURA-bit product with upper half in hi and lower half in lo.
REQ-023 Division SHALL place the quotient in lo and the remainder in hi.
REQ-024 Signed overflow (-2^(LARGURA-1) / -1) SHALL yield lo=0x80000000, hi=0 for LARGURA=32.
REQ-025 Division by zero SHALL set erro_div0=1 and write hi=operando_a, lo=all ones, with pronto at N+1 and ocupado low throughout.
REQ-026 erro_div0 SHALL clear only on reset or on the next accepted inicio that is not a division by zero.
REQ-027 inicio while ocupado=1 or during CONCLUIDO SHALL be ignored.
REQ-028 hi and lo SHALL keep prior values during CALCULA and AJUSTE; intermediate values SHALL NOT appear on hi, lo or saida_dado.
REQ-029 escrita_hi/escrita_lo SHALL update hi/lo with dado_mt on the next edge only in OCIOSO; they SHALL be ignored otherwise.
REQ-030 If escrita_hi or escrita_lo and inicio are asserted together in OCIOSO, the MT write SHALL take effect and the operation SHALL also start, its result later overwriting both.

Reset
REQ-031 reset=1 SHALL, on the next edge, set state OCIOSO, hi=0, lo=0, ocupado=0, pronto=0, erro_div0=0.
REQ-032 reset mid-operation SHALL abort without any result write and without a pronto pulse.
REQ-033 reset SHALL take priority over inicio, escrita_hi and escrita_lo on the same edge.

Verification
REQ-034 MULT 0xFFFFFFFE * 0x00000003 -> pronto at N+34, hi=0xFFFFFFFF, lo=0xFFFFFFFA.
REQ-035 MULTU 0xFFFFFFFF * 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
REQ-036 DIV -7 / 2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); then DIVU 7 / 0 -> pronto at N+1, erro_div0=1, hi=7, lo=0xFFFFFFFF.
REQ-037 During a running op, pulse inicio with new operands and escrita_hi with 0x1234 -> both ignored; the original result is delivered at N+34.
REQ-038 reset at N+10 of a MULT -> no pronto pulse, hi=lo=0; a new MTLO 0xABCD followed by sel_hi=0 -> saida_dado=0x0000ABCD.
